mem_responder: RTL and testbench

//   Memory-side responder for the CPU data/instruction port: accepts one request (read or

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU port and the memory responder.
// The CPU side drives the request; the responder returns ready/ack/data.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, addr, wdata, byte_en,
    input  ready, ack, rdata, err
  );

  modport slave (
    input  req, wr, addr, wdata, byte_en,
    output ready, ack, rdata, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder with programmable wait states.
// Faulting addresses are acked with err set and never touch the array.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic clk,
  input  logic reset,
  mem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] word;
  logic        fault;
  logic [IW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Decode the latched address into a word index and a fault flag.
  always_comb begin
    word  = (addr_q - BASE_ADDR) >> 2;
    fault = (addr_q[1:0] != 2'b00)
         || (addr_q < BASE_ADDR)
         || (word >= 32'(DEPTH_WORDS));
    idx   = word[IW-1:0];
  end

  // Next-state logic: accept in IDLE, count waits, one access, one ack.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) state_nx = S_ACCESS;
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register, request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.req) begin
        wr_q    <= bus.wr;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.byte_en;
        cnt     <= 4'(WAIT_CYCLES);
      end
      if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_ACCESS) begin
        err_q   <= fault;
        rdata_q <= (fault || wr_q) ? 32'h0 : mem[idx];
      end
    end
  end

  // Array write on the ACCESS exit edge; an async reset leaves
  // the FSM in IDLE so an aborted write never reaches this point.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && wr_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.ack   = (state == S_RESP);
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written
// corner sequences and a randomized run against a word-array model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]  reqv;
  logic [2:0]  wrv;
  logic [31:0] addrv [3];
  logic [31:0] wdv [3];
  logic [3:0]  bev [3];
  logic [2:0]  rdy;
  logic [2:0]  ackv;
  logic [2:0]  errv;
  logic [31:0] rdv [3];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  assign bus0.req = reqv[0];
  assign bus0.wr = wrv[0];
  assign bus0.addr = addrv[0];
  assign bus0.wdata = wdv[0];
  assign bus0.byte_en = bev[0];
  assign rdy[0] = bus0.ready;
  assign ackv[0] = bus0.ack;
  assign errv[0] = bus0.err;
  assign rdv[0] = bus0.rdata;

  assign bus1.req = reqv[1];
  assign bus1.wr = wrv[1];
  assign bus1.addr = addrv[1];
  assign bus1.wdata = wdv[1];
  assign bus1.byte_en = bev[1];
  assign rdy[1] = bus1.ready;
  assign ackv[1] = bus1.ack;
  assign errv[1] = bus1.err;
  assign rdv[1] = bus1.rdata;

  assign bus2.req = reqv[2];
  assign bus2.wr = wrv[2];
  assign bus2.addr = addrv[2];
  assign bus2.wdata = wdv[2];
  assign bus2.byte_en = bev[2];
  assign rdy[2] = bus2.ready;
  assign ackv[2] = bus2.ack;
  assign errv[2] = bus2.err;
  assign rdv[2] = bus2.rdata;

  mem_responder #(
    .DEPTH_WORDS(256), .WAIT_CYCLES(2),
    .BASE_ADDR(32'h0)
  ) u0 (.clk(clk), .reset(reset), .bus(bus0));

  mem_responder #(
    .DEPTH_WORDS(16), .WAIT_CYCLES(0),
    .BASE_ADDR(32'h0)
  ) u1 (.clk(clk), .reset(reset), .bus(bus1));

  mem_responder #(
    .DEPTH_WORDS(64), .WAIT_CYCLES(1),
    .BASE_ADDR(32'h1000)
  ) u2 (.clk(clk), .reset(reset), .bus(bus2));

  int          wc [3]    = '{2, 0, 1};
  int unsigned depth [3] = '{256, 16, 64};
  logic [31:0] base [3]  = '{32'h0, 32'h0, 32'h1000};

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mdl [16];

  typedef struct {
    int          k;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Edge E0 accepts; ack must be seen at edge E0+W+2,
  // ready low at edges E0+1..E0+W+2 and high at E0+W+3.
  task automatic run(input int k, input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] be,
                     input logic [31:0] er,
                     input bit ee,
                     input string nm);
    int g;
    int lat;
    bit rlow;
    @(negedge clk);
    g = 0;
    while (!rdy[k] && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({nm, " idle"}, 32'(rdy[k]), 32'd1);
    reqv[k] = 1'b1;
    wrv[k] = w;
    addrv[k] = a;
    wdv[k] = d;
    bev[k] = be;
    @(posedge clk);
    #1;
    reqv[k] = 1'b0;
    wdv[k] = $urandom;
    addrv[k] = $urandom;
    lat = 0;
    rlow = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rdy[k]) rlow = 1'b0;
      if (ackv[k]) break;
    end
    chk({nm, " lat"}, 32'(lat), 32'(wc[k] + 2));
    chk({nm, " rdy_lo"}, 32'(rlow), 32'd1);
    chk({nm, " rdata"}, rdv[k], er);
    chk({nm, " err"}, 32'(errv[k]), 32'(ee));
    @(negedge clk);
    chk({nm, " ack1"}, 32'(ackv[k]), 32'd0);
    chk({nm, " rdy_hi"}, 32'(rdy[k]), 32'd1);
  endtask

  function automatic bit bad(int k, logic [31:0] a);
    if (a % 4 != 0) return 1'b1;
    if (a < base[k]) return 1'b1;
    return ((a - base[k]) / 4) >= depth[k];
  endfunction

  // Model of DUT1: returns expected rdata and err, updates words.
  task automatic model(input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] be,
                       output logic [31:0] er,
                       output bit ee);
    int i;
    er = 32'h0;
    ee = bad(1, a);
    if (!ee) begin
      i = int'(a / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
      end else begin
        er = mdl[i];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] er;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          ee;
    bit          w;
    int          g;
    int          acks;
    int          acc;
    int          first;
    int          last;
    int          gaps;

    reqv = '0;
    wrv = '0;
    for (int k = 0; k < 3; k++) begin
      addrv[k] = '0;
      wdv[k] = '0;
      bev[k] = '0;
    end

    tbl.push_back('{0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0});
    tbl.push_back('{0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0});
    tbl.push_back('{0, 0, 32'h13, 32'h0, 4'hF, 32'h0, 1});
    tbl.push_back('{0, 0, 32'h400, 32'h0, 4'hF, 32'h0, 1});
    tbl.push_back('{0, 1, 32'h22, 32'hFFFFFFFF, 4'hF, 32'h0, 1});
    tbl.push_back('{0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0});
    tbl.push_back('{0, 1, 32'h20, 32'h12345678, 4'h0, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0});
    tbl.push_back('{0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h3FC, 32'h0, 4'hF, 32'h0BADF00D, 0});
    tbl.push_back('{0, 1, 32'h8, 32'h0, 4'hF, 32'h0, 0});
    tbl.push_back('{2, 0, 32'hFFC, 32'h0, 4'hF, 32'h0, 1});
    tbl.push_back('{2, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 0});
    tbl.push_back('{2, 0, 32'h1000, 32'h0, 4'hF, 32'hCAFEF00D, 0});
    tbl.push_back('{2, 1, 32'h10FC, 32'h13579BDF, 4'hF, 32'h0, 0});
    tbl.push_back('{2, 0, 32'h10FC, 32'h0, 4'hF, 32'h13579BDF, 0});
    tbl.push_back('{2, 0, 32'h1100, 32'h0, 4'hF, 32'h0, 1});
    tbl.push_back('{2, 1, 32'h0, 32'h55, 4'hF, 32'h0, 1});
    tbl.push_back('{1, 1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h0, 32'h0, 4'hF, 32'hA5A5A5A5, 0});
    tbl.push_back('{1, 0, 32'h40, 32'h0, 4'hF, 32'h0, 1});

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d ready", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("rst%0d ack", k), 32'(ackv[k]), 32'd0);
      chk($sformatf("rst%0d err", k), 32'(errv[k]), 32'd0);
      chk($sformatf("rst%0d rdata", k), rdv[k], 32'h0);
    end
    reset = 1'b1;

    foreach (tbl[i])
      run(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be,
          tbl[i].er, tbl[i].ee, $sformatf("vec%0d", i));

    // Read result held between acks, then reset during a write's WAIT.
    run(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, "hold_rd");
    repeat (3) @(negedge clk);
    chk("hold rdata", rdv[0], 32'hDEADBEEF);
    chk("hold err", 32'(errv[0]), 32'd0);
    reqv[0] = 1'b1;
    wrv[0] = 1'b1;
    addrv[0] = 32'h8;
    wdv[0] = 32'h5;
    bev[0] = 4'hF;
    @(posedge clk);
    #1;
    reqv[0] = 1'b0;
    @(negedge clk);
    chk("mid ready", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort ready", 32'(rdy[0]), 32'd1);
    chk("abort ack", 32'(ackv[0]), 32'd0);
    chk("abort err", 32'(errv[0]), 32'd0);
    chk("abort rdata", rdv[0], 32'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ackv[0]) acks++;
    end
    chk("abort no_ack", 32'(acks), 32'd0);
    reset = 1'b1;
    run(0, 0, 32'h8, 32'h0, 4'hF, 32'h0, 0, "rd_after_rst");

    // Randomized traffic on the zero-wait, 16-word instance.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(1'b1, 32'(i * 4), d, 4'hF, er, ee);
      run(1, 1'b1, 32'(i * 4), d, 4'hF, er, ee,
          $sformatf("init%0d", i));
    end
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 23) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h8000_0000;
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      model(w, a, d, be, er, ee);
      run(1, w, a, d, be, er, ee, $sformatf("rnd%0d", i));
    end

    // req held high for 20 edges with zero wait states.
    @(negedge clk);
    g = 0;
    while (!rdy[1] && g < 20) begin
      @(negedge clk);
      g++;
    end
    reqv[1] = 1'b1;
    wrv[1] = 1'b0;
    addrv[1] = 32'h0;
    bev[1] = 4'hF;
    acks = 0;
    acc = 0;
    first = -1;
    last = -1;
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy[1]) acc++;
      if (ackv[1]) begin
        acks++;
        if (first < 0) first = i;
        else if (i - last != 3) gaps++;
        last = i;
      end
      @(negedge clk);
    end
    reqv[1] = 1'b0;
    g = 0;
    while (!rdy[1] && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("stream acks", 32'(acks), 32'd6);
    chk("stream accepts", 32'(acc), 32'd7);
    chk("stream first", 32'(first), 32'd2);
    chk("stream gaps", 32'(gaps), 32'd0);
    chk("stream rdata", rdv[1], mdl[0]);
    chk("stream err", 32'(errv[1]), 32'd0);
    chk("stream idle", 32'(rdy[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
